// File: rtl/fft_peak_finder.sv
// Streaming peak search over one FFT frame: squared magnitude per bin, running
// maximum over bins MIN_BIN..N/2-1, one report pulse per frame.
module fft_peak_finder #(
  parameter int WIDTH   = 16,
  parameter int LOG2N   = 10,
  parameter int MIN_BIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  input  logic [2*WIDTH-1:0]      threshold,
  output logic                    out_valid,
  output logic [LOG2N-1:0]        peak_bin,
  output logic [2*WIDTH-1:0]      peak_mag,
  output logic                    peak_above
);

  localparam int MW = 2 * WIDTH;
  localparam int HALF = 1 << (LOG2N - 1);
  localparam logic [LOG2N-1:0] MIN_TAG  = LOG2N'(MIN_BIN);
  localparam logic [LOG2N-1:0] LAST_TAG = '1;

  // Both squares are non-negative and at most 2^(2W-2), so the sum fits 2W bits unsigned.
  function automatic logic [MW-1:0] mag_sum(input logic signed [MW-1:0] a,
                                            input logic signed [MW-1:0] b);
    return $unsigned(a) + $unsigned(b);
  endfunction

  logic [LOG2N-1:0] cnt;
  logic signed [MW-1:0] re_x, im_x;

  logic                 vld_p1, last_p1;
  logic [LOG2N-1:0]     bin_p1;
  logic signed [MW-1:0] re2_p1, im2_p1;

  logic                 vld_p2, last_p2;
  logic [LOG2N-1:0]     bin_p2;
  logic [MW-1:0]        mag_p2;

  logic [MW-1:0]        best_mag, nxt_mag;
  logic [LOG2N-1:0]     best_bin, nxt_bin;
  logic                 win_p2;

  assign re_x = MW'(in_real);
  assign im_x = MW'(in_imag);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (in_valid) cnt <= cnt + 1'b1;
  end

  // Stage 1: squares
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= in_valid;
    bin_p1  <= cnt;
    last_p1 <= (cnt == LAST_TAG);
    re2_p1  <= re_x * re_x;
    im2_p1  <= im_x * im_x;
  end

  // Stage 2: magnitude
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
    bin_p2  <= bin_p1;
    last_p2 <= last_p1;
    mag_p2  <= mag_sum(re2_p1, im2_p1);
  end

  // Stage 3: running best; the report is taken from the post-update value at the last tag
  assign win_p2 = vld_p2 && (int'(bin_p2) >= MIN_BIN) && (int'(bin_p2) < HALF);

  always_comb begin
    nxt_mag = best_mag;
    nxt_bin = best_bin;
    if (win_p2 && ((bin_p2 == MIN_TAG) || (mag_p2 > best_mag))) begin
      nxt_mag = mag_p2;
      nxt_bin = bin_p2;
    end
  end

  always_ff @(posedge clk) begin
    best_mag <= nxt_mag;
    best_bin <= nxt_bin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_above <= 1'b0;
    end else begin
      out_valid <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        peak_bin   <= nxt_bin;
        peak_mag   <= nxt_mag;
        peak_above <= (nxt_mag >= threshold);
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder with N=16, MIN_BIN=1.
module tb_fft_peak_finder;

  localparam int W = 16;
  localparam int L = 4;
  localparam int N = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic signed [W-1:0] in_real, in_imag;
  logic [2*W-1:0]      threshold;
  logic                out_valid;
  logic [L-1:0]        peak_bin;
  logic [2*W-1:0]      peak_mag;
  logic                peak_above;

  fft_peak_finder #(.WIDTH(W), .LOG2N(L), .MIN_BIN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .threshold(threshold), .out_valid(out_valid), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .peak_above(peak_above)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int fre[N];
  int fim[N];
  int pulses = 0;
  int base;
  logic [L-1:0]   rec_bin[$];
  logic [2*W-1:0] rec_mag[$];
  bit             hold_en = 1'b0;
  logic [L-1:0]   prev_bin;
  logic [2*W-1:0] prev_mag;
  logic           prev_above;

  task automatic chk(input string name, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Pulse recorder; outputs must not move except on a pulse
  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      rec_bin.push_back(peak_bin);
      rec_mag.push_back(peak_mag);
    end else if (hold_en) begin
      chk("hold_bin", peak_bin, prev_bin);
      chk("hold_mag", peak_mag, prev_mag);
      chk("hold_above", peak_above, prev_above);
    end
    prev_bin   = peak_bin;
    prev_mag   = peak_mag;
    prev_above = peak_above;
  end

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic drive_frame(input bit gaps, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_real  = 16'($urandom);
          in_imag  = 16'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_real  = 16'(fre[i]);
      in_imag  = 16'(fim[i]);
    end
  endtask

  // Called in the cycle that carries bin N-1: pulse expected exactly 3 cycles later
  task automatic expect_report(input string name, input int eb, input longint em, input int ea);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_lat2"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_pulse"}, out_valid, 1);
    chk({name, "_bin"}, peak_bin, eb);
    chk({name, "_mag"}, peak_mag, em);
    chk({name, "_above"}, peak_above, ea);
    @(negedge clk);
    chk({name, "_single"}, out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; threshold = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_bin", peak_bin, 0);
    chk("rst_mag", peak_mag, 0);
    chk("rst_above", peak_above, 0);
    hold_en = 1'b1;

    clear_frame(); fre[5] = 300; fim[5] = -400;
    drive_frame(1'b0, N);
    expect_report("tone", 5, 250000, 1);

    clear_frame(); fre[0] = 32767; fre[12] = 32767; fre[3] = 10;
    drive_frame(1'b0, N);
    expect_report("window", 3, 100, 1);

    clear_frame(); fre[1] = -32768; fim[1] = -32768;
    drive_frame(1'b0, N);
    expect_report("ovf", 1, 64'd2147483648, 1);

    clear_frame(); fim[2] = 100; fim[6] = 100; threshold = 32'd10001;
    drive_frame(1'b0, N);
    expect_report("tie", 2, 10000, 0);
    threshold = 32'd10000;
    drive_frame(1'b0, N);
    expect_report("thr_eq", 2, 10000, 1);

    threshold = '0;
    base = pulses;
    clear_frame(); fre[4] = 50;
    drive_frame(1'b1, N);
    clear_frame(); fre[7] = 60;
    drive_frame(1'b1, N);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && pulses < base + 2; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("b2b_pulses", pulses - base, 2);
    if (rec_bin.size() >= base + 2) begin
      chk("b2b_a_bin", rec_bin[base], 4);
      chk("b2b_a_mag", rec_mag[base], 2500);
      chk("b2b_b_bin", rec_bin[base+1], 7);
      chk("b2b_b_mag", rec_mag[base+1], 3600);
    end

    clear_frame(); fre[3] = 1000;
    drive_frame(1'b0, 10);
    @(negedge clk);
    in_valid = 1'b0;
    hold_en  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_bin", peak_bin, 0);
    chk("mid_rst_mag", peak_mag, 0);
    chk("mid_rst_above", peak_above, 0);
    hold_en = 1'b1;
    base = pulses;
    clear_frame(); fre[2] = 20;
    drive_frame(1'b0, N);
    chk("mid_rst_no_pulse", pulses - base, 0);
    expect_report("after_rst", 2, 400, 1);
    chk("after_rst_pulses", pulses - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
